// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage with valid/ready handshake and flush.
// Define LOAD_USE_INTERLOCK_EN to add the load-use interlock and its stall counter.
module decode_stage #(
   parameter int unsigned               ADDR_WIDTH     = 32,
   parameter int unsigned               DATA_WIDTH     = 32,
   parameter int unsigned               REG_ADDR_WIDTH = 5,
   parameter logic [ADDR_WIDTH-1:0]     PC_ADDR        = 32'h8000_0000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ADDR_WIDTH-1:0]     in_pc,
   input  logic [31:0]               in_inst,
   input  logic                      flush,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ADDR_WIDTH-1:0]     out_pc,
   output logic [DATA_WIDTH-1:0]     out_imm,
   output logic [2:0]                out_imm_type,
   output logic [6:0]                out_opcode,
   output logic [2:0]                out_funct3,
   output logic [6:0]                out_funct7,
   output logic [REG_ADDR_WIDTH-1:0] out_rs1,
   output logic [REG_ADDR_WIDTH-1:0] out_rs2,
   output logic [REG_ADDR_WIDTH-1:0] out_rd,
   output logic                      out_reg_we,
   output logic                      out_is_load,
   output logic                      out_illegal,
   output logic [31:0]               stall_cnt
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] IMM_NONE = 3'd0;
   localparam logic [2:0] IMM_I    = 3'd1;
   localparam logic [2:0] IMM_S    = 3'd2;
   localparam logic [2:0] IMM_B    = 3'd3;
   localparam logic [2:0] IMM_U    = 3'd4;
   localparam logic [2:0] IMM_J    = 3'd5;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0]     pc;
      logic [DATA_WIDTH-1:0]     imm;
      logic [2:0]                imm_type;
      logic [6:0]                opcode;
      logic [2:0]                funct3;
      logic [6:0]                funct7;
      logic [REG_ADDR_WIDTH-1:0] rs1;
      logic [REG_ADDR_WIDTH-1:0] rs2;
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic                      reg_we;
      logic                      is_load;
      logic                      illegal;
   } dec_t;

   // All immediates take their sign from inst[31], including U when DATA_WIDTH > 32.
   function automatic logic [DATA_WIDTH-1:0] imm_i(input logic [31:0] ins);
      logic signed [11:0] raw;
      raw = ins[31:20];
      return DATA_WIDTH'(raw);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] imm_s(input logic [31:0] ins);
      logic signed [11:0] raw;
      raw = {ins[31:25], ins[11:7]};
      return DATA_WIDTH'(raw);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] imm_b(input logic [31:0] ins);
      logic signed [12:0] raw;
      raw = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      return DATA_WIDTH'(raw);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] imm_u(input logic [31:0] ins);
      logic signed [31:0] raw;
      raw = {ins[31:12], 12'b0};
      return DATA_WIDTH'(raw);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] imm_j(input logic [31:0] ins);
      logic signed [20:0] raw;
      raw = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      return DATA_WIDTH'(raw);
   endfunction

   dec_t       dec;
   dec_t       out_q, out_d;
   logic       valid_q, valid_d;
   logic       hazard;
   logic       accept;
   logic [2:0] dec_type;
   logic       rs1_en, rs2_en, wr_en, load_en, illegal_en;

   always_comb begin
      dec_type   = IMM_NONE;
      rs1_en     = 1'b0;
      rs2_en     = 1'b0;
      wr_en      = 1'b0;
      load_en    = 1'b0;
      illegal_en = 1'b0;
      case (in_inst[6:0])
         OPC_LUI, OPC_AUIPC: begin
            dec_type = IMM_U;
            wr_en    = 1'b1;
         end
         OPC_JAL: begin
            dec_type = IMM_J;
            wr_en    = 1'b1;
         end
         OPC_JALR, OPC_OPIMM: begin
            dec_type = IMM_I;
            rs1_en   = 1'b1;
            wr_en    = 1'b1;
         end
         OPC_LOAD: begin
            dec_type = IMM_I;
            rs1_en   = 1'b1;
            wr_en    = 1'b1;
            load_en  = 1'b1;
         end
         OPC_STORE: begin
            dec_type = IMM_S;
            rs1_en   = 1'b1;
            rs2_en   = 1'b1;
         end
         OPC_BRANCH: begin
            dec_type = IMM_B;
            rs1_en   = 1'b1;
            rs2_en   = 1'b1;
         end
         OPC_OP: begin
            rs1_en = 1'b1;
            rs2_en = 1'b1;
            wr_en  = 1'b1;
         end
         default: illegal_en = 1'b1;
      endcase
   end

   always_comb begin
      dec          = '0;
      dec.pc       = in_pc;
      dec.imm_type = dec_type;
      dec.opcode   = in_inst[6:0];
      dec.funct3   = in_inst[14:12];
      dec.funct7   = in_inst[31:25];
      dec.rs1      = rs1_en ? REG_ADDR_WIDTH'(in_inst[19:15]) : '0;
      dec.rs2      = rs2_en ? REG_ADDR_WIDTH'(in_inst[24:20]) : '0;
      dec.rd       = wr_en  ? REG_ADDR_WIDTH'(in_inst[11:7])  : '0;
      dec.reg_we   = wr_en && (in_inst[11:7] != 5'd0);
      dec.is_load  = load_en;
      dec.illegal  = illegal_en;
      case (dec_type)
         IMM_I:   dec.imm = imm_i(in_inst);
         IMM_S:   dec.imm = imm_s(in_inst);
         IMM_B:   dec.imm = imm_b(in_inst);
         IMM_U:   dec.imm = imm_u(in_inst);
         IMM_J:   dec.imm = imm_j(in_inst);
         default: dec.imm = '0;
      endcase
   end

`ifdef LOAD_USE_INTERLOCK_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic [31:0] stall_q, stall_d;

   // Unread register fields decode as 0 and a held load has rd != 0, so plain equality suffices.
   assign hazard  = valid_q && out_q.is_load && (out_q.rd != '0) && in_valid &&
                    ((dec.rs1 == out_q.rd) || (dec.rs2 == out_q.rd));
   assign stall_d = (hazard && out_ready) ? sat_inc(stall_q) : stall_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) stall_q <= '0;
      else        stall_q <= stall_d;
   end

   assign stall_cnt = stall_q;
`else
   assign hazard    = 1'b0;
   assign stall_cnt = '0;
`endif

   assign in_ready = (!valid_q || out_ready) && !hazard && !flush;
   assign accept   = in_valid && in_ready;

   always_comb begin
      valid_d = valid_q;
      out_d   = out_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d = 1'b1;
         out_d   = dec;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   // Output pipeline register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q  <= 1'b0;
         out_q    <= '0;
         out_q.pc <= PC_ADDR;
      end else begin
         valid_q  <= valid_d;
         out_q    <= out_d;
      end
   end

   assign out_valid    = valid_q;
   assign out_pc       = out_q.pc;
   assign out_imm      = out_q.imm;
   assign out_imm_type = out_q.imm_type;
   assign out_opcode   = out_q.opcode;
   assign out_funct3   = out_q.funct3;
   assign out_funct7   = out_q.funct7;
   assign out_rs1      = out_q.rs1;
   assign out_rs2      = out_q.rs2;
   assign out_rd       = out_q.rd;
   assign out_reg_we   = out_q.reg_we;
   assign out_is_load  = out_q.is_load;
   assign out_illegal  = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table vectors, directed handshake/flush/reset/interlock sequences,
// and a randomized run against an arithmetic reference decoder.
`timescale 1ns/1ps
module tb_decode_stage;

   localparam logic [31:0] PC0 = 32'h8000_0000;
`ifdef LOAD_USE_INTERLOCK_EN
   localparam bit INTERLOCK = 1'b1;
`else
   localparam bit INTERLOCK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_pc = '0;
   logic [31:0] in_inst = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_pc, out_imm;
   logic [2:0]  out_imm_type, out_funct3;
   logic [6:0]  out_opcode, out_funct7;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic        out_reg_we, out_is_load, out_illegal;
   logic [31:0] stall_cnt;

   always #5 clk = ~clk;

   decode_stage #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .PC_ADDR(PC0)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_inst(in_inst), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
      .out_imm_type(out_imm_type), .out_opcode(out_opcode), .out_funct3(out_funct3),
      .out_funct7(out_funct7), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_reg_we(out_reg_we), .out_is_load(out_is_load), .out_illegal(out_illegal),
      .stall_cnt(stall_cnt)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [2:0]  typ;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rs1, rs2, rd;
      logic        we, ld, ill;
   } exp_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] imm;
      logic [2:0]  typ;
      logic [4:0]  rs1, rs2, rd;
      logic        we, ld, ill;
   } vec_t;

   typedef enum {F_X, F_I, F_S, F_B, F_U, F_J, F_R} fmt_e;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference decoder: formats from the opcode table, immediates by signed arithmetic.
   function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
      exp_t e;
      fmt_e f;
      int   s;
      s     = int'(i);
      e     = '0;
      e.pc  = pc;
      e.opc = i[6:0];
      e.f3  = i[14:12];
      e.f7  = i[31:25];
      case (i[6:0])
         7'h37, 7'h17:        f = F_U;
         7'h6F:               f = F_J;
         7'h67, 7'h03, 7'h13: f = F_I;
         7'h23:               f = F_S;
         7'h63:               f = F_B;
         7'h33:               f = F_R;
         default:             f = F_X;
      endcase
      if (f == F_X) begin
         e.ill = 1'b1;
         return e;
      end
      case (f)
         F_I: begin e.typ = 3'd1; e.imm = 32'(s >>> 20); end
         F_S: begin e.typ = 3'd2; e.imm = 32'((s >>> 25) * 32 + int'(i[11:7])); end
         F_B: begin
            e.typ = 3'd3;
            e.imm = 32'((s >>> 31) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 +
                        int'(i[11:8]) * 2);
         end
         F_U: begin e.typ = 3'd4; e.imm = i & 32'hFFFF_F000; end
         F_J: begin
            e.typ = 3'd5;
            e.imm = 32'((s >>> 31) * 1048576 + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 +
                        int'(i[30:21]) * 2);
         end
         default: e.typ = 3'd0;
      endcase
      if (f inside {F_I, F_S, F_B, F_R}) e.rs1 = i[19:15];
      if (f inside {F_S, F_B, F_R})      e.rs2 = i[24:20];
      if (f inside {F_U, F_J, F_I, F_R}) begin
         e.rd = i[11:7];
         e.we = (i[11:7] != 5'd0);
      end
      e.ld = (i[6:0] == 7'h03);
      return e;
   endfunction

   task automatic chk_out(input string tag, input exp_t e);
      chk({tag, ".pc"},      out_pc,       e.pc);
      chk({tag, ".imm"},     out_imm,      e.imm);
      chk({tag, ".imm_type"},out_imm_type, e.typ);
      chk({tag, ".opcode"},  out_opcode,   e.opc);
      chk({tag, ".funct3"},  out_funct3,   e.f3);
      chk({tag, ".funct7"},  out_funct7,   e.f7);
      chk({tag, ".rs1"},     out_rs1,      e.rs1);
      chk({tag, ".rs2"},     out_rs2,      e.rs2);
      chk({tag, ".rd"},      out_rd,       e.rd);
      chk({tag, ".reg_we"},  out_reg_we,   e.we);
      chk({tag, ".is_load"}, out_is_load,  e.ld);
      chk({tag, ".illegal"}, out_illegal,  e.ill);
   endtask

   function automatic logic [31:0] rand_inst();
      logic [6:0] op;
      case ($urandom_range(0, 9))
         0: op = 7'h37;
         1: op = 7'h17;
         2: op = 7'h6F;
         3: op = 7'h67;
         4: op = 7'h63;
         5: op = 7'h03;
         6: op = 7'h23;
         7: op = 7'h13;
         8: op = 7'h33;
         default: op = 7'($urandom);
      endcase
      return {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              3'($urandom), 5'($urandom_range(0, 7)), op};
   endfunction

   localparam logic [31:0] I_ADDI = 32'h0050_8193;  // addi x3,x1,5
   localparam logic [31:0] I_ADD  = 32'h0072_8333;  // add  x6,x5,x7
   localparam logic [31:0] I_SW   = 32'hFE20_AC23;  // sw   x2,-8(x1)
   localparam logic [31:0] I_LW   = 32'h0000_A283;  // lw   x5,0(x1)
   localparam logic [31:0] I_LUI  = 32'h1234_50B7;  // lui  x1,0x12345

   vec_t tbl [14];
   exp_t m_e, ne;
   logic m_valid, hz, exp_ready;
   logic [31:0] m_stall;

   initial begin
      tbl[0]  = '{32'h123450B7, 32'h12345000, 3'd4, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{32'hFE208EE3, 32'hFFFFFFFC, 3'd3, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{32'hFFFFFFFF, 32'h00000000, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1};
      tbl[3]  = '{32'h00508193, 32'h00000005, 3'd1, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{32'hFE20AC23, 32'hFFFFFFF8, 3'd2, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{32'h0000A283, 32'h00000000, 3'd1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0};
      tbl[6]  = '{32'h008000EF, 32'h00000008, 3'd5, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{32'hFFFFF117, 32'hFFFFF000, 3'd4, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{32'h00008067, 32'h00000000, 3'd1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{32'h00000000, 32'h00000000, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1};
      tbl[11] = '{32'h00000013, 32'h00000000, 3'd1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{32'h00728333, 32'h00000000, 3'd0, 5'd5, 5'd7, 5'd6, 1'b1, 1'b0, 1'b0};
      tbl[13] = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0};

      // Reset state
      #1 reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst.out_valid", out_valid, 1'b0);
      chk("rst.out_pc", out_pc, PC0);
      chk("rst.stall_cnt", stall_cnt, 32'd0);
      chk_out("rst", '{pc: PC0, default: '0});
      reset = 1'b1;
      #1 chk("rst.in_ready", in_ready, 1'b1);

      // Table vectors, back-to-back with out_ready=1
      for (int k = 0; k < 14; k++) begin
         in_valid = 1'b1;
         in_inst  = tbl[k].inst;
         in_pc    = 32'h0000_1000 + 32'(k * 4);
         #1 chk("vec.in_ready", in_ready, 1'b1);
         @(negedge clk);
         chk("vec.out_valid", out_valid, 1'b1);
         chk("vec.pc", out_pc, 32'h0000_1000 + 32'(k * 4));
         chk("vec.imm", out_imm, tbl[k].imm);
         chk("vec.imm_type", out_imm_type, tbl[k].typ);
         chk("vec.opcode", out_opcode, tbl[k].inst[6:0]);
         chk("vec.funct3", out_funct3, tbl[k].inst[14:12]);
         chk("vec.funct7", out_funct7, tbl[k].inst[31:25]);
         chk("vec.rs1", out_rs1, tbl[k].rs1);
         chk("vec.rs2", out_rs2, tbl[k].rs2);
         chk("vec.rd", out_rd, tbl[k].rd);
         chk("vec.reg_we", out_reg_we, tbl[k].we);
         chk("vec.is_load", out_is_load, tbl[k].ld);
         chk("vec.illegal", out_illegal, tbl[k].ill);
      end

      // Backpressure: hold for 5 cycles, then resume without drop or duplicate
      in_inst = I_ADDI; in_pc = 32'h2000;
      @(negedge clk);
      chk_out("bp.a", ref_decode(I_ADDI, 32'h2000));
      out_ready = 1'b0;
      in_inst = I_ADD; in_pc = 32'h2004;
      for (int c = 0; c < 5; c++) begin
         #1 chk("bp.in_ready", in_ready, 1'b0);
         @(negedge clk);
         chk("bp.out_valid", out_valid, 1'b1);
         chk_out("bp.hold", ref_decode(I_ADDI, 32'h2000));
      end
      out_ready = 1'b1;
      #1 chk("bp.release_ready", in_ready, 1'b1);
      @(negedge clk);
      chk_out("bp.b", ref_decode(I_ADD, 32'h2004));
      in_inst = I_SW; in_pc = 32'h2008;
      @(negedge clk);
      chk("bp.c_valid", out_valid, 1'b1);
      chk_out("bp.c", ref_decode(I_SW, 32'h2008));
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp.drained", out_valid, 1'b0);

      // Load-use: LW x5 followed by a consumer of x5
      in_valid = 1'b1; in_inst = I_LW; in_pc = 32'h3000;
      @(negedge clk);
      chk_out("lu.lw", ref_decode(I_LW, 32'h3000));
      in_inst = I_ADD; in_pc = 32'h3004;
      #1;
      if (INTERLOCK) begin
         chk("lu.in_ready_stall", in_ready, 1'b0);
         @(negedge clk);
         chk("lu.bubble", out_valid, 1'b0);
         chk("lu.stall_cnt", stall_cnt, 32'd1);
         #1 chk("lu.in_ready_after", in_ready, 1'b1);
      end else begin
         chk("lu.in_ready", in_ready, 1'b1);
      end
      @(negedge clk);
      chk("lu.add_valid", out_valid, 1'b1);
      chk_out("lu.add", ref_decode(I_ADD, 32'h3004));
      chk("lu.stall_final", stall_cnt, INTERLOCK ? 32'd1 : 32'd0);

      // Flush while full with a pending input
      out_ready = 1'b0; in_inst = I_ADDI; in_pc = 32'h4000; flush = 1'b1;
      #1 chk("fl.in_ready", in_ready, 1'b0);
      @(negedge clk);
      chk("fl.out_valid", out_valid, 1'b0);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("fl.not_consumed", out_valid, 1'b0);
      in_valid = 1'b1; in_inst = I_SW; in_pc = 32'h4004;
      @(negedge clk);
      chk_out("fl.next", ref_decode(I_SW, 32'h4004));

      // Reset mid-stream takes effect without a clock edge
      in_inst = I_LUI; in_pc = 32'h5000;
      #2 reset = 1'b0;
      #1;
      chk("mr.out_valid", out_valid, 1'b0);
      chk("mr.out_pc", out_pc, PC0);
      chk("mr.out_imm", out_imm, 32'd0);
      chk("mr.stall_cnt", stall_cnt, 32'd0);
      @(negedge clk);
      reset = 1'b1; in_valid = 1'b0;
      #1 chk("mr.in_ready", in_ready, 1'b1);
      @(negedge clk);
      chk("mr.no_replay", out_valid, 1'b0);

      // Randomized run against the reference model
      m_valid = 1'b0;
      m_e     = '0;
      m_stall = '0;
      for (int c = 0; c < 3000; c++) begin
         chk("rnd.out_valid", out_valid, m_valid);
         if (m_valid) chk_out("rnd", m_e);
         chk("rnd.stall_cnt", stall_cnt, m_stall);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_inst   = rand_inst();
         in_pc     = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         #1;
         ne = ref_decode(in_inst, in_pc);
         hz = INTERLOCK && m_valid && m_e.ld && (m_e.rd != 5'd0) && in_valid &&
              (((ne.typ inside {3'd1, 3'd2, 3'd3}) || (ne.typ == 3'd0 && !ne.ill)) &&
                  (in_inst[19:15] == m_e.rd) ||
               ((ne.typ inside {3'd2, 3'd3}) || (ne.typ == 3'd0 && !ne.ill)) &&
                  (in_inst[24:20] == m_e.rd));
         exp_ready = (!m_valid || out_ready) && !hz && !flush;
         chk("rnd.in_ready", in_ready, exp_ready);
         if (hz && out_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
         if (flush) m_valid = 1'b0;
         else if (in_valid && exp_ready) begin
            m_valid = 1'b1;
            m_e     = ne;
         end else if (out_ready) m_valid = 1'b0;
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
